crossing_counter: RTL and testbench

CROSSING_COUNTER -- requirements
Module: crossing_counter

---
 rtl/crossing_pkg.sv | 16 +
 rtl/crossing_lane.sv | 80 ++++++++
 rtl/crossing_counter.sv | 62 ++++++
 tb/tb_crossing_counter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/crossing_pkg.sv
// crossing_pkg: lane state encoding and synchronized sensor patterns {l,r}
package crossing_pkg;
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      L1   = 3'd1,
      LB   = 3'd2,
      LX   = 3'd3,
      R1   = 3'd4,
      RB   = 3'd5,
      RX   = 3'd6
   } lane_state_t;
   localparam logic [1:0] S_NONE = 2'b00;
   localparam logic [1:0] S_L    = 2'b10;
   localparam logic [1:0] S_R    = 2'b01;
   localparam logic [1:0] S_BOTH = 2'b11;
endpackage

// File: rtl/crossing_lane.sv
// crossing_lane: one two-beam lane with synchronizer, direction FSM, stall timer and pulses
module crossing_lane
   import crossing_pkg::*;
#(
   parameter int TIMEOUT = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sens_l,
   input  logic sens_r,
   output logic lr_pulse,
   output logic rl_pulse,
   output logic abort_pulse
);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   logic [1:0] sync1, s;
   logic [TW-1:0] timer;
   lane_state_t state, state_n;
   logic lr_n, rl_n, ab_n;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync1       <= '0;
         s           <= '0;
         state       <= IDLE;
         timer       <= '0;
         lr_pulse    <= 1'b0;
         rl_pulse    <= 1'b0;
         abort_pulse <= 1'b0;
      end else begin
         sync1       <= {sens_l, sens_r};
         s           <= sync1;
         state       <= state_n;
         timer       <= (state_n != state || state == IDLE) ? '0 : timer + TW'(1);
         lr_pulse    <= lr_n;
         rl_pulse    <= rl_n;
         abort_pulse <= ab_n;
      end
   // a stall wins over whatever the beams do in the same cycle
   always_comb begin
      state_n = state;
      lr_n    = 1'b0;
      rl_n    = 1'b0;
      ab_n    = 1'b0;
      if (state != IDLE && timer == T_LAST) begin
         state_n = IDLE;
         ab_n    = 1'b1;
      end else
         case (state)
            IDLE: state_n = s == S_L ? L1 : s == S_R ? R1 : IDLE;
            L1: begin
               state_n = s == S_BOTH ? LB : s == S_L ? L1 : IDLE;
               ab_n    = s == S_R;
            end
            LB: begin
               state_n = s == S_R ? LX : s == S_L ? L1 : s == S_NONE ? IDLE : LB;
               ab_n    = s == S_NONE;
            end
            LX: begin
               state_n = s == S_BOTH ? LB : s == S_R ? LX : IDLE;
               lr_n    = s == S_NONE;
               ab_n    = s == S_L;
            end
            R1: begin
               state_n = s == S_BOTH ? RB : s == S_R ? R1 : IDLE;
               ab_n    = s == S_L;
            end
            RB: begin
               state_n = s == S_L ? RX : s == S_R ? R1 : s == S_NONE ? IDLE : RB;
               ab_n    = s == S_NONE;
            end
            RX: begin
               state_n = s == S_BOTH ? RB : s == S_L ? RX : IDLE;
               rl_n    = s == S_NONE;
               ab_n    = s == S_R;
            end
            default: state_n = IDLE;
         endcase
   end
endmodule

// File: rtl/crossing_counter.sv
// crossing_counter: multi-lane crossing detector with wrapping totals and a saturating net count
module crossing_counter
   import crossing_pkg::*;
#(
   parameter int LANES   = 2,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 1000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [LANES-1:0]        sens_l,
   input  logic [LANES-1:0]        sens_r,
   input  logic                    clr,
   output logic [LANES-1:0]        lr_pulse,
   output logic [LANES-1:0]        rl_pulse,
   output logic [LANES-1:0]        abort_pulse,
   output logic [CNT_W-1:0]        total_lr,
   output logic [CNT_W-1:0]        total_rl,
   output logic signed [CNT_W:0]   net
);
   localparam int PW = $clog2(LANES + 1);
   localparam int NW = CNT_W + 6;
   localparam logic signed [NW-1:0] LIM = NW'((1 << CNT_W) - 1);
   logic [PW-1:0] n_lr, n_rl;
   logic signed [NW-1:0] net_x, net_s;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      crossing_lane #(.TIMEOUT(TIMEOUT)) u_lane (
         .clk         (clk),
         .rst_n       (rst_n),
         .sens_l      (sens_l[i]),
         .sens_r      (sens_r[i]),
         .lr_pulse    (lr_pulse[i]),
         .rl_pulse    (rl_pulse[i]),
         .abort_pulse (abort_pulse[i])
      );
   end
   // net is evaluated in a wider signed domain so the clamp sees the true sum
   always_comb begin
      n_lr = '0;
      n_rl = '0;
      for (int k = 0; k < LANES; k++) begin
         n_lr = n_lr + PW'(lr_pulse[k]);
         n_rl = n_rl + PW'(rl_pulse[k]);
      end
      net_x = NW'(net) + $signed(NW'(n_lr)) - $signed(NW'(n_rl));
      net_s = net_x > LIM ? LIM : net_x < -LIM ? -LIM : net_x;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         total_lr <= '0;
         total_rl <= '0;
         net      <= '0;
      end else if (clr) begin
         total_lr <= '0;
         total_rl <= '0;
         net      <= '0;
      end else begin
         total_lr <= total_lr + CNT_W'(n_lr);
         total_rl <= total_rl + CNT_W'(n_rl);
         net      <= net_s[CNT_W:0];
      end
endmodule

// File: tb/tb_crossing_counter.sv
// tb_crossing_counter: directed and randomized checks against a path-position model of each lane
module tb_crossing_counter;
   localparam int LANES = 2, CNT_W = 8, TIMEOUT = 20, MAXN = 255;
   logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
   logic [LANES-1:0] sens_l = '0, sens_r = '0, lr_pulse, rl_pulse, abort_pulse;
   logic [CNT_W-1:0] total_lr, total_rl;
   logic signed [CNT_W:0] net;
   int checks = 0, errors = 0;
   int m, tl, tr, tn, lr_seen = 0, ab_seen = 0, last_ab = -1000;
   int pos [LANES], dir [LANES], ent [LANES], wpos [LANES], wdir [LANES];
   logic [1:0] d1 [LANES], d2 [LANES];
   logic [LANES-1:0] e_lr, e_rl, e_ab;
   always #5 clk = ~clk;
   crossing_counter #(.LANES(LANES), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .sens_l(sens_l), .sens_r(sens_r), .clr(clr),
      .lr_pulse(lr_pulse), .rl_pulse(rl_pulse), .abort_pulse(abort_pulse),
      .total_lr(total_lr), .total_rl(total_rl), .net(net)
   );
   // pattern {l,r} at position p along the path of direction d (+1 = L->R, -1 = R->L)
   function automatic logic [1:0] pat(input int d, input int p);
      return (p == 0 || p == 4) ? 2'b00 : p == 2 ? 2'b11 : ((p == 1) == (d == 1)) ? 2'b10 : 2'b01;
   endfunction
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic model_init();
      m = 0; tl = 0; tr = 0; tn = 0;
      e_lr = '0; e_rl = '0; e_ab = '0;
      for (int i = 0; i < LANES; i++) begin
         pos[i] = 0; dir[i] = 0; ent[i] = 0; d1[i] = 2'b00; d2[i] = 2'b00;
      end
   endtask
   task automatic step(input logic [1:0] p0, input logic [1:0] p1, input logic c);
      logic [1:0] x;
      sens_l = {p1[1], p0[1]};
      sens_r = {p1[0], p0[0]};
      clr = c;
      @(posedge clk); #1;
      m++;
      if (c) begin
         tl = 0; tr = 0; tn = 0;
      end else begin
         tl = (tl + $countones(e_lr)) % (1 << CNT_W);
         tr = (tr + $countones(e_rl)) % (1 << CNT_W);
         tn = tn + $countones(e_lr) - $countones(e_rl);
         tn = tn > MAXN ? MAXN : tn < -MAXN ? -MAXN : tn;
      end
      e_lr = '0; e_rl = '0; e_ab = '0;
      for (int i = 0; i < LANES; i++) begin
         x = d2[i];
         d2[i] = d1[i];
         d1[i] = i == 0 ? p0 : p1;
         if (pos[i] != 0 && m - ent[i] == TIMEOUT) begin
            e_ab[i] = 1'b1; pos[i] = 0;
         end else if (pos[i] == 0) begin
            if (x == 2'b10 || x == 2'b01) begin
               dir[i] = x == 2'b10 ? 1 : -1; pos[i] = 1; ent[i] = m;
            end
         end else if (x != pat(dir[i], pos[i])) begin
            ent[i] = m;
            if (x == pat(dir[i], pos[i] + 1)) begin
               pos[i]++;
               if (pos[i] == 4) begin
                  if (dir[i] == 1) e_lr[i] = 1'b1; else e_rl[i] = 1'b1;
                  pos[i] = 0;
               end
            end else if (x == pat(dir[i], pos[i] - 1)) pos[i]--;
            else begin
               e_ab[i] = 1'b1; pos[i] = 0;
            end
         end
      end
      chk("lr_pulse", int'(lr_pulse), int'(e_lr));
      chk("rl_pulse", int'(rl_pulse), int'(e_rl));
      chk("abort_pulse", int'(abort_pulse), int'(e_ab));
      chk("total_lr", int'(total_lr), tl);
      chk("total_rl", int'(total_rl), tr);
      chk("net", int'(net), tn);
      lr_seen += $countones(lr_pulse);
      ab_seen += $countones(abort_pulse);
      if (abort_pulse[0]) last_ab = m;
   endtask
   task automatic hold(input logic [1:0] p0, input logic [1:0] p1, input int n, input logic c = 1'b0);
      for (int k = 0; k < n; k++) step(p0, p1, c);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      chk("rst_lr_pulse", int'(lr_pulse), 0);
      chk("rst_rl_pulse", int'(rl_pulse), 0);
      chk("rst_abort", int'(abort_pulse), 0);
      chk("rst_total_lr", int'(total_lr), 0);
      chk("rst_total_rl", int'(total_rl), 0);
      chk("rst_net", int'(net), 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      model_init();
   endtask
   task automatic rnd_pat(input int i, output logic [1:0] p);
      if ($urandom_range(0, 3) == 0) p = 2'($urandom);
      else begin
         wpos[i]++;
         if (wpos[i] > 4) begin
            wpos[i] = 1;
            wdir[i] = $urandom_range(0, 1) ? 1 : -1;
         end
         p = pat(wdir[i], wpos[i]);
      end
   endtask
   initial begin
      int l0, a0, k0, n;
      logic found;
      logic [1:0] rp0, rp1;
      #1;
      do_reset();
      hold(2'b00, 2'b00, 3);
      hold(2'b10, 2'b00, 5); hold(2'b11, 2'b00, 5); hold(2'b01, 2'b00, 5); hold(2'b00, 2'b00, 5);
      chk("lr_cross_total_lr", int'(total_lr), 1);
      chk("lr_cross_total_rl", int'(total_rl), 0);
      chk("lr_cross_net", int'(net), 1);
      hold(2'b00, 2'b00, 1, 1'b1);
      hold(2'b00, 2'b01, 5); hold(2'b00, 2'b11, 5); hold(2'b00, 2'b10, 5); hold(2'b00, 2'b00, 5);
      chk("rl_cross_total_rl", int'(total_rl), 1);
      chk("rl_cross_total_lr", int'(total_lr), 0);
      chk("rl_cross_net", int'(net), -1);
      l0 = lr_seen; a0 = ab_seen;
      hold(2'b10, 2'b00, 5); hold(2'b11, 2'b00, 5); hold(2'b10, 2'b00, 5);
      hold(2'b11, 2'b00, 5); hold(2'b01, 2'b00, 5); hold(2'b00, 2'b00, 5);
      chk("hesitate_lr", lr_seen - l0, 1);
      chk("hesitate_abort", ab_seen - a0, 0);
      l0 = lr_seen; a0 = ab_seen;
      hold(2'b10, 2'b00, 5); hold(2'b01, 2'b00, 5); hold(2'b00, 2'b00, 5);
      chk("jump_abort", ab_seen - a0, 1);
      chk("jump_lr", lr_seen - l0, 0);
      a0 = ab_seen;
      hold(2'b10, 2'b00, 3); hold(2'b11, 2'b00, 1);
      k0 = m;
      hold(2'b11, 2'b00, TIMEOUT + 4);
      chk("timeout_cycle", last_ab - k0, TIMEOUT + 2);
      chk("timeout_aborts", ab_seen - a0, 1);
      hold(2'b00, 2'b00, 5);
      hold(2'b00, 2'b00, 1, 1'b1);
      hold(2'b10, 2'b10, 2); hold(2'b11, 2'b11, 2); hold(2'b01, 2'b01, 2); hold(2'b00, 2'b00, 5);
      chk("both_total_lr", int'(total_lr), 2);
      hold(2'b00, 2'b00, 1, 1'b1);
      for (int k = 0; k < 127; k++) begin
         hold(2'b10, 2'b10, 1); hold(2'b11, 2'b11, 1); hold(2'b01, 2'b01, 1); hold(2'b00, 2'b00, 1);
      end
      hold(2'b00, 2'b00, 5);
      chk("wrap_pre_total", int'(total_lr), 254);
      hold(2'b10, 2'b00, 1); hold(2'b11, 2'b00, 1); hold(2'b01, 2'b00, 1); hold(2'b00, 2'b00, 5);
      chk("wrap_255_total", int'(total_lr), 255);
      chk("wrap_255_net", int'(net), 255);
      hold(2'b10, 2'b00, 1); hold(2'b11, 2'b00, 1); hold(2'b01, 2'b00, 1); hold(2'b00, 2'b00, 5);
      chk("wrap_zero_total", int'(total_lr), 0);
      chk("wrap_net_clamp", int'(net), 255);
      hold(2'b10, 2'b00, 3); hold(2'b11, 2'b00, 3); hold(2'b01, 2'b00, 3);
      do_reset();
      l0 = lr_seen;
      hold(2'b00, 2'b00, 6);
      chk("reset_mid_lr", lr_seen - l0, 0);
      hold(2'b10, 2'b00, 2); hold(2'b11, 2'b00, 2); hold(2'b01, 2'b00, 2);
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         hold(2'b00, 2'b00, 1);
         found = lr_pulse[0];
      end
      chk("clr_pulse_seen", int'(found), 1);
      hold(2'b00, 2'b00, 1, 1'b1);
      chk("clr_prio_total_lr", int'(total_lr), 0);
      chk("clr_prio_net", int'(net), 0);
      for (int i = 0; i < LANES; i++) begin
         wpos[i] = 0; wdir[i] = 1;
      end
      for (int k = 0; k < 200; k++) begin
         rnd_pat(0, rp0);
         rnd_pat(1, rp1);
         n = $urandom_range(0, 15) == 0 ? TIMEOUT + 3 : $urandom_range(1, 4);
         hold(rp0, rp1, n, $urandom_range(0, 30) == 0);
      end
      hold(2'b00, 2'b00, 6);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
